// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Definitions shared by the reaction game blocks (state controller and
// reaction_timer).
//   - Controller state encodings seen on the 3-bit state bus. Any code with
//     bit 2 set is GO_BUFFS.
//   - BCD_MAX: the saturation value of the 4-digit BCD counters.
//   - rt_state_t: reaction_timer FSM states.
//   - bcd_inc(): one-step ripple increment of a 4-digit BCD value.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam logic [2:0]  HI_SCORE   = 3'b000;
    localparam logic [2:0]  DELAYING   = 3'b001;
    localparam logic [2:0]  TIMING     = 3'b010;
    localparam logic [2:0]  DISPLAYING = 3'b011;

    localparam logic [15:0] BCD_MAX    = 16'h9999;

    typedef enum logic [1:0] {
        RT_IDLE = 2'd0,
        RT_RUN  = 2'd1,
        RT_DONE = 2'd2
    } rt_state_t;

    // Digit 9 rolls to 0 and carries into the next digit. Callers must not
    // pass BCD_MAX; the counter saturates before that.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// ---------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD counter that saturates at 9999.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset (q=0, sat=0)
//   clr  in   synchronous clear (q=0, sat=0), priority over inc
//   inc  in   advance the count by one when not saturated
//   q    out  registered count, 4 BCD digits
//   sat  out  registered flag: the count has reached 9999
// ---------------------------------------------------------------------------
module bcd_counter4
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q,
    output logic        sat
);

    logic [15:0] r_q;
    logic        r_sat;
    logic [15:0] w_next;

    assign w_next = bcd_inc(r_q);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q   <= 16'h0000;
            r_sat <= 1'b0;
        end else if (inc && (r_q != BCD_MAX)) begin
            r_q   <= w_next;
            // Raise the flag on the same edge the count lands on 9999.
            r_sat <= (w_next == BCD_MAX);
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/reaction_timer.sv
// ---------------------------------------------------------------------------
// reaction_timer
// Measures reaction time in ticks of TICK_HZ (ms by default) while the game
// controller sits in TIMING, captures the count on the stop press and keeps
// the best (lowest) non-overflowed score of the session.
// Parameters:
//   CLK_HZ, TICK_HZ  count rate divider DIV = CLK_HZ/TICK_HZ (integer, >= 2)
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   state_i[2:0]   in   controller state (000/001/010/011, 1xx = GO_BUFFS)
//   stop_i         in   one-cycle stop press
//   clear_hi_i     in   one-cycle pulse: forget the best score
//   cur_bcd_o      out  live count, BCD
//   score_bcd_o    out  last captured score, BCD
//   score_valid_o  out  score_bcd_o holds a real capture
//   hi_bcd_o       out  best score, BCD (9999 when none)
//   hi_valid_o     out  a best score exists
//   new_hi_o       out  last capture set a new best
//   running_o      out  FSM is in RUN
//   overflow_o     out  count saturated at 9999
// All outputs are registered.
// ---------------------------------------------------------------------------
module reaction_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state_i,
    input  logic        stop_i,
    input  logic        clear_hi_i,
    output logic [15:0] cur_bcd_o,
    output logic [15:0] score_bcd_o,
    output logic        score_valid_o,
    output logic [15:0] hi_bcd_o,
    output logic        hi_valid_o,
    output logic        new_hi_o,
    output logic        running_o,
    output logic        overflow_o
);

    localparam int             DIV        = CLK_HZ / TICK_HZ;
    localparam int             PW         = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

    rt_state_t      r_state;
    rt_state_t      w_next_state;
    logic [2:0]     r_prev_state;
    logic [PW-1:0]  r_presc;
    logic [15:0]    r_score;
    logic           r_score_valid;
    logic [15:0]    r_hi;
    logic           r_hi_valid;
    logic           r_new_hi;
    logic           r_running;

    logic           w_entry;
    logic           w_in_timing;
    logic           w_run;
    logic           w_capture;
    logic           w_abort;
    logic           w_counting;
    logic           w_tick;
    logic [15:0]    w_cur;
    logic           w_sat;
    logic           w_hi_update;

    assign w_in_timing = (state_i == TIMING);
    assign w_entry     = w_in_timing && (r_prev_state != TIMING);
    assign w_run       = (r_state == RT_RUN);

    // Entry has priority over everything in RUN; a stop on the entry cycle
    // is therefore never a capture.
    assign w_capture   = w_run && stop_i && !w_entry;
    // GO_BUFFS (1xx) is simply "not TIMING" here. Capture wins over abort.
    assign w_abort     = w_run && !w_in_timing && !stop_i;
    // Counting stops on the capture edge so DONE shows the captured count.
    assign w_counting  = w_run && w_in_timing && !stop_i && !w_entry;
    assign w_tick      = w_counting && (r_presc == PRESC_LAST);

    // Unsigned compare is a valid BCD magnitude compare: digits are ordered.
    assign w_hi_update = w_capture && !w_sat && !clear_hi_i &&
                         (!r_hi_valid || (w_cur < r_hi));

    bcd_counter4 u_counter (
        .clk (clk),
        .rst (rst),
        .clr (w_entry),
        .inc (w_tick),
        .q   (w_cur),
        .sat (w_sat)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state
    always_comb begin
        w_next_state = r_state;
        if (w_entry) begin
            w_next_state = RT_RUN;
        end else begin
            case (r_state)
                RT_RUN: begin
                    if (w_capture) begin
                        w_next_state = RT_DONE;
                    end else if (w_abort) begin
                        w_next_state = RT_IDLE;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    // Previous controller state for entry detection, prescaler and
    // running flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_state <= HI_SCORE;
            r_presc      <= '0;
            r_running    <= 1'b0;
        end else begin
            r_prev_state <= state_i;
            r_running    <= (w_next_state == RT_RUN);
            if (w_entry) begin
                r_presc <= '0;
            end else if (w_counting) begin
                r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            end
        end
    end

    // Capture and score flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score       <= 16'h0000;
            r_score_valid <= 1'b0;
            r_new_hi      <= 1'b0;
        end else if (w_entry) begin
            r_score_valid <= 1'b0;
            r_new_hi      <= 1'b0;
        end else if (w_capture) begin
            r_score       <= w_cur;
            r_score_valid <= 1'b1;
            r_new_hi      <= w_hi_update;
        end else if (w_abort) begin
            r_score_valid <= 1'b0;
        end
    end

    // Best score; clear_hi_i applies in any FSM state.
    always_ff @(posedge clk) begin
        if (rst || clear_hi_i) begin
            r_hi       <= BCD_MAX;
            r_hi_valid <= 1'b0;
        end else if (w_hi_update) begin
            r_hi       <= w_cur;
            r_hi_valid <= 1'b1;
        end
    end

    assign cur_bcd_o     = w_cur;
    assign overflow_o    = w_sat;
    assign score_bcd_o   = r_score;
    assign score_valid_o = r_score_valid;
    assign hi_bcd_o      = r_hi;
    assign hi_valid_o    = r_hi_valid;
    assign new_hi_o      = r_new_hi;
    assign running_o     = r_running;

endmodule

// File: tb/tb_reaction_timer.sv
// ---------------------------------------------------------------------------
// tb_reaction_timer
// Main DUT at DIV=10. A second instance at DIV=2 reaches saturation in a
// short run. Expected scores come from elapsed-cycle arithmetic and an
// integer best-score model.
// ---------------------------------------------------------------------------
module tb_reaction_timer;
    import game_pkg::*;

    localparam int DIV   = 10;
    localparam int DIV_F = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // main DUT
    logic [2:0]  state;
    logic        stop, clear_hi;
    logic [15:0] cur, score, hi;
    logic        score_valid, hi_valid, new_hi, running, overflow;

    reaction_timer #(.CLK_HZ(1000), .TICK_HZ(100)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .state_i       (state),
        .stop_i        (stop),
        .clear_hi_i    (clear_hi),
        .cur_bcd_o     (cur),
        .score_bcd_o   (score),
        .score_valid_o (score_valid),
        .hi_bcd_o      (hi),
        .hi_valid_o    (hi_valid),
        .new_hi_o      (new_hi),
        .running_o     (running),
        .overflow_o    (overflow)
    );

    // fast DUT for saturation
    logic [2:0]  f_state;
    logic        f_stop, f_clear;
    logic [15:0] f_cur, f_score, f_hi;
    logic        f_score_valid, f_hi_valid, f_new_hi, f_running, f_overflow;

    reaction_timer #(.CLK_HZ(2), .TICK_HZ(1)) u_dut_fast (
        .clk           (clk),
        .rst           (rst),
        .state_i       (f_state),
        .stop_i        (f_stop),
        .clear_hi_i    (f_clear),
        .cur_bcd_o     (f_cur),
        .score_bcd_o   (f_score),
        .score_valid_o (f_score_valid),
        .hi_bcd_o      (f_hi),
        .hi_valid_o    (f_hi_valid),
        .new_hi_o      (f_new_hi),
        .running_o     (f_running),
        .overflow_o    (f_overflow)
    );

    // scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    // reference model of the best score (plain integers)
    int m_hi;
    bit m_hi_valid;
    bit m_new_hi;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance n edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".cur"}, cur, 16'h0000);
        check_eq({tag, ".score"}, score, 16'h0000);
        check_eq({tag, ".score_valid"}, 16'(score_valid), 16'h0);
        check_eq({tag, ".hi"}, hi, 16'h9999);
        check_eq({tag, ".hi_valid"}, 16'(hi_valid), 16'h0);
        check_eq({tag, ".new_hi"}, 16'(new_hi), 16'h0);
        check_eq({tag, ".running"}, 16'(running), 16'h0);
        check_eq({tag, ".overflow"}, 16'(overflow), 16'h0);
    endtask

    // Leaves the bench just after entry edge E.
    task automatic enter_timing(input bit stop_on_entry);
        state = DELAYING;
        step($urandom_range(1, 4));
        state = TIMING;
        stop  = stop_on_entry;
        step(1);
        stop = 1'b0;
        check_eq("entry.running", 16'(running), 16'h1);
        check_eq("entry.cur", cur, 16'h0000);
        check_eq("entry.score_valid", 16'(score_valid), 16'h0);
        check_eq("entry.new_hi", 16'(new_hi), 16'h0);
    endtask

    // Stop is driven d cycles after the entry edge, so it is sampled at
    // edge E+d+1 and the captured count is d/DIV.
    task automatic play_round(input int d, input bit clr, input bit leave,
                              input bit stop_on_entry);
        int score_int;
        logic [15:0] exp_score;
        enter_timing(stop_on_entry);
        step(d);
        check_eq("run.cur", cur, to_bcd(d / DIV));
        stop     = 1'b1;
        clear_hi = clr;
        if (leave) state = DISPLAYING;
        step(1);
        stop     = 1'b0;
        clear_hi = 1'b0;

        score_int = d / DIV;
        exp_q.push_back(to_bcd(score_int));
        if (clr) begin
            m_hi       = 9999;
            m_hi_valid = 1'b0;
            m_new_hi   = 1'b0;
        end else if (!m_hi_valid || score_int < m_hi) begin
            m_hi       = score_int;
            m_hi_valid = 1'b1;
            m_new_hi   = 1'b1;
        end else begin
            m_new_hi   = 1'b0;
        end

        exp_score = exp_q.pop_front();
        check_eq("cap.score", score, exp_score);
        check_eq("cap.score_valid", 16'(score_valid), 16'h1);
        check_eq("cap.hi", hi, to_bcd(m_hi));
        check_eq("cap.hi_valid", 16'(hi_valid), 16'(m_hi_valid));
        check_eq("cap.new_hi", 16'(new_hi), 16'(m_new_hi));
        check_eq("cap.running", 16'(running), 16'h0);

        state = DISPLAYING;
        step(3);
        check_eq("done.score", score, exp_score);
        check_eq("done.cur", cur, exp_score);
    endtask

    task automatic abort_round(input int d);
        enter_timing(1'b0);
        step(d);
        state = 3'(4 + $urandom_range(0, 3));
        step(1);
        check_eq("abort.running", 16'(running), 16'h0);
        check_eq("abort.score_valid", 16'(score_valid), 16'h0);
        check_eq("abort.hi", hi, to_bcd(m_hi));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check_eq("abort_stop.running", 16'(running), 16'h0);
        check_eq("abort_stop.score_valid", 16'(score_valid), 16'h0);
        check_eq("abort_stop.hi", hi, to_bcd(m_hi));
        check_eq("abort_stop.hi_valid", 16'(hi_valid), 16'(m_hi_valid));
    endtask

    initial begin
        rst      = 1'b1;
        state    = HI_SCORE;
        stop     = 1'b0;
        clear_hi = 1'b0;
        f_state  = HI_SCORE;
        f_stop   = 1'b0;
        f_clear  = 1'b0;
        m_hi       = 9999;
        m_hi_valid = 1'b0;
        m_new_hi   = 1'b0;

        step(3);
        check_reset_values("reset");
        rst = 1'b0;

        // stop in IDLE is ignored
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check_eq("idle_stop.running", 16'(running), 16'h0);
        check_eq("idle_stop.score_valid", 16'(score_valid), 16'h0);

        // directed rounds
        play_round(235, 1'b0, 1'b0, 1'b0);
        play_round(150, 1'b0, 1'b0, 1'b0);
        play_round(400, 1'b0, 1'b0, 1'b0);
        abort_round(77);
        play_round(99, 1'b0, 1'b1, 1'b1);
        play_round(300, 1'b1, 1'b0, 1'b0);
        play_round(180, 1'b0, 1'b0, 1'b0);

        // stop in DONE is ignored
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check_eq("done_stop.score", score, to_bcd(18));
        check_eq("done_stop.running", 16'(running), 16'h0);

        // clear_hi outside a capture
        clear_hi = 1'b1;
        step(1);
        clear_hi   = 1'b0;
        m_hi       = 9999;
        m_hi_valid = 1'b0;
        check_eq("clear.hi", hi, 16'h9999);
        check_eq("clear.hi_valid", 16'(hi_valid), 16'h0);

        // randomized rounds
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                abort_round($urandom_range(0, 300));
            end
            play_round($urandom_range(0, 700),
                       ($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0));
        end

        // reset mid-run
        enter_timing(1'b0);
        step(420);
        check_eq("midrun.cur", cur, 16'h0042);
        rst   = 1'b1;
        state = HI_SCORE;
        step(1);
        rst = 1'b0;
        m_hi       = 9999;
        m_hi_valid = 1'b0;
        m_new_hi   = 1'b0;
        check_reset_values("midrun_reset");

        // saturation on the fast instance: first set a best of 25
        f_state = DELAYING;
        step(2);
        f_state = TIMING;
        step(1);
        step(50);
        f_stop = 1'b1;
        step(1);
        f_stop = 1'b0;
        check_eq("fast.score", f_score, to_bcd(50 / DIV_F));
        check_eq("fast.hi", f_hi, to_bcd(50 / DIV_F));
        check_eq("fast.new_hi", 16'(f_new_hi), 16'h1);
        f_state = DISPLAYING;
        step(2);
        f_state = TIMING;
        step(1);
        check_eq("ovf_entry.new_hi", 16'(f_new_hi), 16'h0);
        check_eq("ovf_entry.running", 16'(f_running), 16'h1);
        step(DIV_F * 9998);
        check_eq("ovf_pre.cur", f_cur, to_bcd(9998));
        check_eq("ovf_pre.overflow", 16'(f_overflow), 16'h0);
        step(DIV_F * 5);
        check_eq("ovf.cur", f_cur, 16'h9999);
        check_eq("ovf.overflow", 16'(f_overflow), 16'h1);
        f_stop = 1'b1;
        step(1);
        f_stop = 1'b0;
        check_eq("ovf_cap.score", f_score, 16'h9999);
        check_eq("ovf_cap.score_valid", 16'(f_score_valid), 16'h1);
        check_eq("ovf_cap.hi", f_hi, to_bcd(50 / DIV_F));
        check_eq("ovf_cap.hi_valid", 16'(f_hi_valid), 16'h1);
        check_eq("ovf_cap.new_hi", 16'(f_new_hi), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
# reaction_timer

Measures the player's reaction time in milliseconds and keeps the best (lowest) score of the session. It sits directly downstream of the game state controller: it watches the controller's 3-bit state, starts counting on entry to TIMING, and captures the count on the player's stop press. Its BCD outputs feed the HEX display driver, and its status flags feed the LEDs.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `TICK_HZ`, default 1000: count rate; DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- `clk`  in  1  system clock (MAX10_CLK1_50). Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `state_i`  in  3  controller state: HI_SCORE=000, DELAYING=001, TIMING=010, DISPLAYING=011, GO_BUFFS=1xx.
- `stop_i`  in  1  one-cycle pulse, synchronous and debounced upstream; the player pressed stop.
- `clear_hi_i`  in  1  one-cycle pulse that forgets the best score.
- `cur_bcd_o`  out  16  live count, 4 BCD digits.
- `score_bcd_o`  out  16  last captured score in BCD.
- `score_valid_o`  out  1  `score_bcd_o` holds a real capture.
- `hi_bcd_o`  out  16  best score in BCD.
- `hi_valid_o`  out  1  a best score exists.
- `new_hi_o`  out  1  the last capture set a new best.
- `running_o`  out  1  the FSM is in RUN.
- `overflow_o`  out  1  the count has saturated at 9999.

## Operation
- FSM states: IDLE, RUN, DONE.
- An entry to TIMING is a cycle where `state_i`==010 and the registered previous `state_i` != 010.
- **Entry to TIMING, from any FSM state:**
  - go to RUN;
  - clear the prescaler and `cur_bcd_o`;
  - clear `overflow_o`, `new_hi_o` and `score_valid_o`.
- **Counting in RUN:**
  - the prescaler counts 0..DIV-1;
  - at DIV-1 it wraps to 0 and `cur_bcd_o` increments by 1 as a BCD ripple (digit 9 goes to 0 with a carry).
- **Saturation:** at 16'h9999 the count holds and `overflow_o` goes to 1.
- **stop_i in RUN, capture:**
  - `score_bcd_o` takes the registered `cur_bcd_o` value before any same-cycle increment;
  - `score_valid_o` goes to 1;
  - the FSM goes to DONE.
- **Best-score update:** applies when `overflow_o`==0 and (`hi_valid_o`==0 or score < `hi_bcd_o`). Then:
  - `hi_bcd_o` takes the score;
  - `hi_valid_o` goes to 1;
  - `new_hi_o` goes to 1 and holds until the next entry to TIMING.
- **Overflowed capture:** never updates the best score.
- **stop_i outside RUN:** ignored. This includes IDLE, DONE and the entry cycle itself; false starts are the controller's job.
- **Leaving TIMING in RUN without stop_i (abort):**
  - go to IDLE;
  - `score_valid_o` goes to 0;
  - the best score is untouched;
  - GO_BUFFS (1xx) counts as leaving TIMING.
- **Simultaneous stop_i and leaving TIMING:** the capture wins.
- **clear_hi_i, any state:**
  - `hi_bcd_o` goes to 16'h9999 and `hi_valid_o` to 0;
  - if it coincides with a capture, the score is still captured but the best is not updated and `new_hi_o` stays 0.
- **DONE:** holds all outputs until the next entry to TIMING.

## Timing
- **Reset values:**
  - FSM = IDLE, prescaler = 0;
  - `cur_bcd_o`=0, `score_bcd_o`=0, `score_valid_o`=0;
  - `hi_bcd_o`=16'h9999, `hi_valid_o`=0;
  - `new_hi_o`=0, `running_o`=0, `overflow_o`=0.
- **Reset mid-run:** same reset values; the best score is lost.
- All outputs are registered.
- Entry is sampled at edge E: `running_o`=1 after E. `cur_bcd_o` reaches 1 after edge E+DIV and reaches N after E+N·DIV.
- Capture: `stop_i` is sampled at edge S; `score_bcd_o`, `hi_bcd_o` and `new_hi_o` update at S, so they are visible 1 cycle later. `running_o`=0 after S.
- Abort latency is 1 cycle.
- The BCD compare is a plain 16-bit unsigned compare, which is valid because the digits are ordered.

## Structure
- **Shared package `game_pkg`:**
  - state encodings: `HI_SCORE`, `DELAYING`, `TIMING`, `DISPLAYING`, with GO_BUFFS detected as `state_i[2]`;
  - `BCD_MAX` = 16'h9999;
  - used by this block and by the state controller.
- **Sub-module `bcd_counter4`:**
  - 4-digit BCD counter with ports `clk`, `rst`, `clr`, `inc`, saturating at 9999;
  - outputs `q[15:0]` and `sat`.
- The prescaler, FSM, capture and best-score logic live in `reaction_timer`.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- **Nominal capture:** reset, then state 001 → 010, then `stop_i` 235 cycles after entry → `score_bcd_o`=16'h0023, `score_valid_o`=1, `hi_bcd_o`=16'h0023, `hi_valid_o`=1, `new_hi_o`=1.
- **Best-score compare:** a second round stopped at 150 cycles → `score_bcd_o`=16'h0015, `hi_bcd_o`=16'h0015, `new_hi_o`=1. A third round at 400 cycles → `score_bcd_o`=16'h0040, `hi_bcd_o` stays 16'h0015, `new_hi_o`=0.
- **Overflow:** hold TIMING for 100,000 cycles → `cur_bcd_o`=16'h9999, `overflow_o`=1. Then `stop_i` → `score_bcd_o`=16'h9999 and `hi_bcd_o` is unchanged.
- **Abort:** in RUN, `state_i` goes to 1xx with no stop → IDLE 1 cycle later, `score_valid_o`=0, `hi_bcd_o` unchanged. A `stop_i` afterwards is ignored.
- **Simultaneous events:**
  - `stop_i` together with `state_i` 010 → 011 → captured;
  - `stop_i` together with a tick at count 9 → score 16'h0009;
  - `clear_hi_i` together with a capture → `hi_bcd_o`=16'h9999, `hi_valid_o`=0, score captured.
- **Reset mid-run:** `rst` at count 16'h0042 → all outputs at their reset values, including `hi_bcd_o`=16'h9999.
